// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (read-only) and the data stage.
// Data has fixed priority, bounded by a starvation counter; a watchdog aborts hung accesses.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              d_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              bus_err
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StBusyD = 2'd1;
   localparam logic [1:0] StBusyI = 2'd2;

   localparam int unsigned WaitW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit          WdogEn   = (TIMEOUT_CYCLES != 0);
   localparam logic [WaitW-1:0] WaitLast =
      WaitW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  StarveMax = 4'(STARVE_LIMIT);

   logic [1:0]        state_q, state_d;
   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
   logic              bus_err_q, bus_err_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic busy, timeout, finish, grant_i, grant_d;

   always_comb begin
      busy    = (state_q != StIdle);
      // Watchdog fires on the last allowed wait cycle, only while the memory is still stalling.
      timeout = WdogEn && busy && !mem_ready && (wait_cnt_q == WaitLast);
      finish  = busy && (mem_ready || timeout);
      grant_i = (state_q == StIdle) && if_req && (!d_req || (starve_cnt_q == StarveMax));
      grant_d = (state_q == StIdle) && !grant_i && d_req;

      if_done  = (state_q == StBusyI) && finish;
      d_done   = (state_q == StBusyD) && finish;
      if_rdata = (if_done && mem_ready) ? mem_rdata : '0;
      d_rdata  = (d_done && mem_ready && !mem_we_q) ? mem_rdata : '0;
      if_stall = if_req && !if_done;
      d_stall  = d_req && !d_done;

      mem_req   = mem_req_q;
      mem_we    = mem_we_q;
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
      bus_err   = bus_err_q;
   end

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      bus_err_d    = bus_err_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;

      case (state_q)
         StIdle: begin
            wait_cnt_d = '0;
            if (grant_i) begin
               state_d      = StBusyI;
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_addr_d   = if_addr;
               mem_wdata_d  = '0;
               starve_cnt_d = '0;
            end else if (grant_d) begin
               state_d     = StBusyD;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               if (if_req && (starve_cnt_q != StarveMax)) begin
                  starve_cnt_d = starve_cnt_q + 4'd1;
               end
            end
         end
         StBusyD, StBusyI: begin
            if (finish) begin
               state_d    = StIdle;
               mem_req_d  = 1'b0;
               wait_cnt_d = '0;
               if (timeout) begin
                  bus_err_d = 1'b1;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + WaitW'(1);
            end
         end
         default: begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         starve_cnt_q <= '0;
         wait_cnt_q   <= '0;
         bus_err_q    <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         bus_err_q    <= bus_err_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers queue expected accesses and results,
// a monitor pops and compares on every grant and completion.
module tb_mem_port_arbiter;

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned LIMIT = 4;
   localparam int unsigned TMO   = 8;

   typedef logic [95:0] v_t;
   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } acc_t;

   logic          clk, reset;
   logic          if_req, if_done, if_stall;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          d_req, d_we, d_done, d_stall;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic          mem_req, mem_we, mem_ready, bus_err;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
      .d_done(d_done), .d_stall(d_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   acc_t        acc_if_q[$];
   acc_t        acc_d_q[$];
   logic [31:0] exp_if_q[$];
   logic [31:0] exp_d_q[$];
   bit          grant_log[$];
   int          vec_cnt = 0;
   int          err_cnt = 0;
   int          cfg_wait = 0;  // >=0 fixed wait states, -1 random 0..3, -2 never ready
   logic        exp_bus_err = 1'b0;

   // Memory contents are a pure function of the address.
   function automatic logic [31:0] hash(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input v_t act, input v_t want);
      vec_cnt++;
      if (act !== want) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic note_fail(input string name);
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s: event missing or unexpected at %0t", name, $time);
   endtask

   task automatic run_fetch(input int n, input bit gaps, input bit fixed,
                            input logic [31:0] faddr, output int lat);
      logic [31:0] a;
      bit          seen;
      lat = 0;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            int g;
            g = int'($urandom_range(0, 3));
            if (g > 0) begin
               if_req = 1'b0;
               repeat (g) begin @(posedge clk); #1; end
            end
         end
         a = fixed ? faddr : ($urandom() & 32'h0000_1FFC);
         acc_if_q.push_back('{a, 1'b0, 32'h0});
         exp_if_q.push_back(hash(a));
         if_req  = 1'b1;
         if_addr = a;
         lat  = 0;
         seen = 1'b0;
         while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            seen = (if_done === 1'b1);
         end
         if (!seen) note_fail("fetch_done_timeout");
         @(posedge clk); #1;
      end
      if_req = 1'b0;
   endtask

   // we_mode: 0 read, 1 write, 2 random
   task automatic run_data(input int n, input bit gaps, input bit fixed,
                           input logic [31:0] faddr, input logic [31:0] fdata,
                           input int we_mode, input bit tmo, output int lat);
      logic [31:0] a, wd;
      logic        we;
      bit          seen;
      lat = 0;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            int g;
            g = int'($urandom_range(0, 3));
            if (g > 0) begin
               d_req = 1'b0;
               repeat (g) begin @(posedge clk); #1; end
            end
         end
         a  = fixed ? faddr : (32'h0000_2000 | ($urandom() & 32'h0000_1FFC));
         wd = fixed ? fdata : $urandom();
         we = (we_mode == 2) ? 1'($urandom_range(0, 1)) : (we_mode == 1);
         acc_d_q.push_back('{a, we, wd});
         exp_d_q.push_back((tmo || we) ? 32'h0 : hash(a));
         d_req   = 1'b1;
         d_we    = we;
         d_addr  = a;
         d_wdata = wd;
         lat  = 0;
         seen = 1'b0;
         while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            seen = (d_done === 1'b1);
         end
         if (!seen) note_fail("data_done_timeout");
         @(posedge clk); #1;
      end
      d_req = 1'b0;
   endtask

   // Memory responder: picks a wait count at the start of each access.
   initial begin : responder
      bit active;
      int wl;
      mem_ready = 1'b0;
      mem_rdata = '0;
      active    = 1'b0;
      wl        = 0;
      forever begin
         @(posedge clk); #1;
         if (mem_req !== 1'b1) begin
            active    = 1'b0;
            mem_ready = 1'b0;
         end else begin
            if (!active) begin
               active = 1'b1;
               if (cfg_wait == -1)      wl = int'($urandom_range(0, 3));
               else if (cfg_wait == -2) wl = 1000000;
               else                     wl = cfg_wait;
            end
            mem_ready = (wl == 0);
            if (wl > 0) wl--;
            mem_rdata = hash(mem_addr);
         end
      end
   end

   initial begin : monitor
      acc_t        cap, want_acc;
      bit          cap_fetch;
      int          busy_cnt;
      int unsigned starve_m;
      logic        mreq_prev, ifreq_prev, dreq_prev;
      logic [31:0] w;
      cap = '0; cap_fetch = 1'b0; busy_cnt = 0; starve_m = 0;
      mreq_prev = 1'b0; ifreq_prev = 1'b0; dreq_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            busy_cnt    = 0;
            starve_m    = 0;
            exp_bus_err = 1'b0;
            mreq_prev   = 1'b0;
            ifreq_prev  = if_req;
            dreq_prev   = d_req;
         end else begin
            if (mem_req && !mreq_prev) begin
               busy_cnt  = 1;
               cap       = '{mem_addr, mem_we, mem_wdata};
               cap_fetch = !mem_addr[13];
               grant_log.push_back(cap_fetch);
               if (cap_fetch) begin
                  chk("fetch_grant_legal",
                      v_t'(ifreq_prev && (!dreq_prev || starve_m == LIMIT)), v_t'(1));
                  starve_m = 0;
                  if (acc_if_q.size() == 0) note_fail("fetch_grant_unexpected");
                  else begin
                     want_acc = acc_if_q.pop_front();
                     chk("fetch_access", v_t'(cap), v_t'(want_acc));
                  end
               end else begin
                  chk("data_grant_legal",
                      v_t'(dreq_prev && (!ifreq_prev || starve_m < LIMIT)), v_t'(1));
                  if (ifreq_prev && starve_m < LIMIT) starve_m++;
                  if (acc_d_q.size() == 0) note_fail("data_grant_unexpected");
                  else begin
                     want_acc = acc_d_q.pop_front();
                     chk("data_access", v_t'(cap), v_t'(want_acc));
                  end
               end
            end else if (mem_req) begin
               busy_cnt++;
               chk("mem_hold", v_t'({mem_addr, mem_we, mem_wdata}), v_t'(cap));
            end

            if (if_done || d_done) begin
               chk("done_port", v_t'({mem_req, if_done, d_done}),
                   v_t'({1'b1, cap_fetch, !cap_fetch}));
               if (!mem_ready) begin
                  chk("wdog_cycles", v_t'(busy_cnt), v_t'(TMO));
                  chk("bus_err_pre", v_t'(bus_err), v_t'(exp_bus_err));
                  exp_bus_err = 1'b1;
               end else begin
                  chk("bus_err", v_t'(bus_err), v_t'(exp_bus_err));
               end
            end

            if (if_done) begin
               if (exp_if_q.size() == 0) note_fail("if_done_unexpected");
               else begin
                  w = exp_if_q.pop_front();
                  chk("if_rdata", v_t'(if_rdata), v_t'(w));
               end
            end else begin
               chk("if_rdata_idle", v_t'(if_rdata), v_t'(0));
            end
            if (d_done) begin
               if (exp_d_q.size() == 0) note_fail("d_done_unexpected");
               else begin
                  w = exp_d_q.pop_front();
                  chk("d_rdata", v_t'(d_rdata), v_t'(w));
               end
            end else begin
               chk("d_rdata_idle", v_t'(d_rdata), v_t'(0));
            end
            chk("if_stall", v_t'(if_stall), v_t'(if_req && !if_done));
            chk("d_stall", v_t'(d_stall), v_t'(d_req && !d_done));

            mreq_prev  = mem_req;
            ifreq_prev = if_req;
            dreq_prev  = d_req;
         end
      end
   end

   initial begin : main
      int lat, lat_b;
      reset = 1'b0;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_outputs", v_t'({mem_req, mem_we, bus_err, if_done, d_done}), v_t'(0));
      chk("rst_mem_addr", v_t'(mem_addr), v_t'(0));
      chk("rst_mem_wdata", v_t'(mem_wdata), v_t'(0));
      chk("rst_rdata", v_t'({if_rdata, d_rdata}), v_t'(0));
      @(posedge clk); #3;
      reset = 1'b1;
      @(posedge clk); #1;

      // Single fetch, zero wait states
      cfg_wait = 0;
      run_fetch(1, 1'b0, 1'b1, 32'h0000_0100, lat);
      chk("fetch_latency", v_t'(lat), v_t'(2));

      // Data write, three wait states
      cfg_wait = 3;
      run_data(1, 1'b0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 1, 1'b0, lat);
      chk("write_latency", v_t'(lat), v_t'(5));

      // Both held high: LIMIT data grants then one fetch, repeating
      cfg_wait = 0;
      grant_log.delete();
      fork
         run_fetch(3, 1'b0, 1'b0, 32'h0, lat);
         run_data(12, 1'b0, 1'b0, 32'h0, 32'h0, 2, 1'b0, lat_b);
      join
      chk("starve_grants", v_t'(grant_log.size()), v_t'(15));
      for (int k = 0; k < 15; k++) begin
         if (k < grant_log.size()) begin
            chk("starve_pattern", v_t'(grant_log[k]), v_t'((k % 5) == 4));
         end
      end

      // Random traffic with random wait states
      cfg_wait = -1;
      fork
         run_fetch(40, 1'b1, 1'b0, 32'h0, lat);
         run_data(60, 1'b1, 1'b0, 32'h0, 32'h0, 2, 1'b0, lat_b);
      join

      // Watchdog: memory never ready
      cfg_wait = -2;
      run_data(1, 1'b0, 1'b1, 32'h0000_2040, 32'h1234_5678, 0, 1'b1, lat);
      chk("wdog_latency", v_t'(lat), v_t'(TMO + 1));
      @(negedge clk);
      chk("bus_err_set", v_t'(bus_err), v_t'(1));
      @(posedge clk); #1;
      cfg_wait = 0;
      run_fetch(1, 1'b0, 1'b1, 32'h0000_0180, lat);
      chk("bus_err_sticky", v_t'(bus_err), v_t'(1));

      // Async reset in the middle of a fetch
      cfg_wait = 5;
      acc_if_q.push_back('{32'h0000_0300, 1'b0, 32'h0});
      exp_if_q.push_back(hash(32'h0000_0300));
      if_addr = 32'h0000_0300;
      if_req  = 1'b1;
      lat = 0;
      while (mem_req !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      chk("reset_test_started", v_t'(mem_req), v_t'(1));
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      chk("async_reset_mem_req", v_t'({mem_req, if_done, bus_err}), v_t'(0));
      acc_if_q.push_back('{32'h0000_0300, 1'b0, 32'h0});
      cfg_wait = 0;
      @(posedge clk); #3;
      reset = 1'b1;
      lat = 0;
      while (if_done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      chk("rearb_fetch_done", v_t'(if_done), v_t'(1));
      chk("rearb_latency", v_t'(lat), v_t'(2));
      @(posedge clk); #1;
      if_req = 1'b0;

      repeat (4) @(negedge clk);
      chk("queues_drained",
          v_t'(acc_if_q.size() + acc_d_q.size() + exp_if_q.size() + exp_d_q.size()), v_t'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin : global_guard
      #500000;
      note_fail("global_timeout");
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (read-only) and the data-memory stage requester (read or write).
- Sits between the pipeline's IF/MEM stages and the external memory port.
- Generates per-port stall signals for the hazard logic.
- Data stage has fixed priority; a starvation limit guarantees fetch progress.
- A wait-state watchdog aborts hung memory transactions.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants while fetch waits before fetch is forced through (1..15).
- TIMEOUT_CYCLES, 64, wait cycles in BUSY before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level; held with if_addr until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data, valid while if_done=1.
- if_done  out  1  fetch completion pulse.
- if_stall  out  1  if_req && !if_done.
- d_req  in  1  data request, level; held with d_we/d_addr/d_wdata until d_done.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, valid while d_done=1.
- d_done  out  1  data completion pulse.
- d_stall  out  1  d_req && !d_done.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1.
- mem_ready  in  1  completes the current access in the same cycle.
- bus_err  out  1  sticky watchdog-abort flag.

Behaviour:
- States: IDLE, BUSY_D, BUSY_I.
- Reset (async, reset=0): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; starve_cnt=0; wait_cnt=0; bus_err=0. All done outputs are 0. Reset asserted mid-transaction drops mem_req immediately; the transaction is discarded.
- Arbitration in IDLE:
  - Fetch is granted (go BUSY_I) when if_req=1 && (d_req=0 || starve_cnt==STARVE_LIMIT).
  - Otherwise data is granted (go BUSY_D) when d_req=1.
  - Otherwise stay in IDLE.
- Grant latching: the chosen requester's addr, we and wdata are latched into the mem_* registers. Fetch always uses mem_we=0 and mem_wdata=0. mem_req=1 from the next cycle.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on a data grant while if_req=1.
  - Clears on any fetch grant.
  - Unchanged otherwise.
- BUSY_x with mem_ready=1:
  - x_done=1 combinationally in that cycle.
  - x_rdata = mem_rdata (fetch and data loads); d_rdata = 0 for writes.
  - Next state is IDLE, mem_req=0, wait_cnt=0.
- BUSY_x with mem_ready=0: hold all mem_* outputs; wait_cnt+1.
- Watchdog: if TIMEOUT_CYCLES≠0 and wait_cnt==TIMEOUT_CYCLES-1 with mem_ready=0:
  - x_done=1 with x_rdata=0.
  - bus_err set, cleared only by reset.
  - Next state IDLE.
- Latency:
  - Minimum is 2 cycles per access: request seen in IDLE at cycle N, mem_req at N+1, done at N+1 if mem_ready.
  - Back-to-back: a requester keeping req high after done is treated as a new request in the following IDLE cycle.
- rdata outputs are 0 whenever the matching done=0.
- A requester dropping req mid-transaction (illegal) does not abort: the access completes and the done pulse still fires.
- Simultaneous d_req and if_req in the same IDLE cycle are resolved by the priority rule above. Only one grant ever occurs per cycle.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, mem_ready=1 always → mem_req/mem_addr=0x100 in cycle 1; if_done with if_rdata=mem_rdata in cycle 1; if_stall=1 only in cycle 0.
- Data write with 3 wait states: d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF → mem_we=1 and mem_wdata stable for 4 cycles; d_done on the 4th; d_rdata=0.
- Priority plus starvation with STARVE_LIMIT=4: both req held high, zero wait states → 4 data grants, then 1 fetch grant, then the pattern repeats; starve_cnt clears after the fetch grant.
- Watchdog with TIMEOUT_CYCLES=8: mem_ready stuck at 0 → d_done with d_rdata=0 exactly 8 cycles after mem_req rises; bus_err=1 and stays 1.
- Async reset mid-BUSY_I: reset=0 between clock edges → mem_req=0 before the next edge; after release, IDLE re-arbitrates the pending if_req normally.
